// File: rtl/e_sync_target.sv
// 68K synchronous-bus (VPA/VMA/E) timer target: reload counter, control/status,
// scratch register and a registered interrupt request.
module e_sync_target #(
  parameter logic [18:0] BASE_ADDR   = 19'h7FFE0,
  parameter logic [15:0] RELOAD_INIT = 16'hFFFF
) (
  input  logic        e_clock,
  input  logic        rst_overflow,
  input  logic [23:1] M68K_A,
  inout  wire  [15:0] M68K_D,
  input  logic        M68K_AS_n,
  input  logic        M68K_UDS_n,
  input  logic        M68K_LDS_n,
  input  logic        M68K_RW,
  input  logic        M68K_VMA_n,
  output logic        M68K_VPA_n,
  output logic        M68K_INT_n
);

  typedef enum logic [1:0] {IDLE, WAIT_VMA, ACCESS, DONE} state_t;

  typedef struct packed {
    logic ie;
    logic oneshot;
    logic run;
  } ctrl_t;

  state_t      state, state_nxt;
  ctrl_t       ctrl;
  logic [15:0] counter, reload, scratch, rd_latch;
  logic        flag;

  logic        sel, hole, access, rd_acc, drive;
  logic [1:0]  idx;
  logic        wr_count, wr_ctrl, wr_scratch, rd_status;
  logic        load, underflow;
  logic [15:0] lane_m, ctrl_rd, ctrl_w, reload_nxt, rd_mux;

  assign sel        = !M68K_AS_n && (M68K_A[23:5] == BASE_ADDR);
  assign idx        = M68K_A[2:1];
  assign hole       = |M68K_A[4:3];
  assign M68K_VPA_n = !sel;

  // The single access edge is the one that leaves IDLE/WAIT_VMA for ACCESS.
  assign access     = sel && !M68K_VMA_n && (state == IDLE || state == WAIT_VMA);
  assign rd_acc     = access && M68K_RW;
  assign wr_count   = access && !M68K_RW && !hole && (idx == 2'd0);
  assign wr_ctrl    = access && !M68K_RW && !hole && (idx == 2'd1);
  assign wr_scratch = access && !M68K_RW && !hole && (idx == 2'd3);
  assign rd_status  = rd_acc && !hole && (idx == 2'd2);

  // Byte-lane merge: unstrobed lanes keep the register's old contents.
  assign lane_m     = {{8{!M68K_UDS_n}}, {8{!M68K_LDS_n}}};
  assign ctrl_rd    = {12'd0, ctrl.ie, 1'b0, ctrl.oneshot, ctrl.run};
  assign ctrl_w     = (ctrl_rd & ~lane_m) | (M68K_D & lane_m);
  assign reload_nxt = wr_count ? ((reload & ~lane_m) | (M68K_D & lane_m)) : reload;

  assign load       = wr_ctrl && ctrl_w[2];
  assign underflow  = ctrl.run && (counter == 16'd0) && !load;

  always_comb begin
    rd_mux = 16'd0;
    if (!hole) begin
      case (idx)
        2'd0:    rd_mux = counter;
        2'd1:    rd_mux = ctrl_rd;
        2'd2:    rd_mux = {ctrl.run, 14'd0, flag};
        default: rd_mux = scratch;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    if (M68K_AS_n) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:     if (sel) state_nxt = M68K_VMA_n ? WAIT_VMA : ACCESS;
        WAIT_VMA: if (sel && !M68K_VMA_n) state_nxt = ACCESS;
        ACCESS:   state_nxt = DONE;
        default:  state_nxt = DONE;
      endcase
    end
  end

  always_ff @(posedge e_clock or posedge rst_overflow) begin
    if (rst_overflow) state <= IDLE;
    else              state <= state_nxt;
  end

  always_ff @(posedge e_clock or posedge rst_overflow) begin
    if (rst_overflow) begin
      counter    <= RELOAD_INIT;
      reload     <= RELOAD_INIT;
      ctrl       <= '0;
      flag       <= 1'b0;
      scratch    <= 16'd0;
      rd_latch   <= 16'd0;
      M68K_INT_n <= 1'b1;
    end else begin
      reload <= reload_nxt;

      if (load)
        counter <= reload;
      else if (ctrl.run)
        counter <= (counter == 16'd0) ? reload_nxt : counter - 16'd1;

      // A software CTRL write overrides the one-shot auto-stop on the same edge.
      if (wr_ctrl)
        ctrl <= '{ie: ctrl_w[3], oneshot: ctrl_w[1], run: ctrl_w[0]};
      else if (underflow && ctrl.oneshot)
        ctrl.run <= 1'b0;

      if (underflow)      flag <= 1'b1;
      else if (rd_status) flag <= 1'b0;

      if (wr_scratch) scratch  <= (scratch & ~lane_m) | (M68K_D & lane_m);
      if (rd_acc)     rd_latch <= rd_mux;

      M68K_INT_n <= !(flag && ctrl.ie);
    end
  end

  assign drive  = (state == ACCESS || state == DONE) && !M68K_AS_n && M68K_RW;
  assign M68K_D = drive ? rd_latch : 16'hzzzz;

endmodule
